// File: rtl/seg7_pkg.sv
// Shared definitions for the seven-segment scan decoder: glyph constants, FSM
// state type and anode-select helpers.
package seg7_pkg;

   localparam int NUM_DIGITS = 8;

   // Active-low gfedcba patterns, bit 0 = segment a
   localparam logic [6:0] SEG7_0 = 7'h40;
   localparam logic [6:0] SEG7_1 = 7'h79;
   localparam logic [6:0] SEG7_2 = 7'h24;
   localparam logic [6:0] SEG7_3 = 7'h30;
   localparam logic [6:0] SEG7_4 = 7'h19;
   localparam logic [6:0] SEG7_5 = 7'h12;
   localparam logic [6:0] SEG7_6 = 7'h02;
   localparam logic [6:0] SEG7_7 = 7'h78;
   localparam logic [6:0] SEG7_8 = 7'h00;
   localparam logic [6:0] SEG7_9 = 7'h10;
   localparam logic [6:0] SEG7_A = 7'h08;
   localparam logic [6:0] SEG7_B = 7'h03;
   localparam logic [6:0] SEG7_C = 7'h46;
   localparam logic [6:0] SEG7_D = 7'h21;
   localparam logic [6:0] SEG7_E = 7'h06;
   localparam logic [6:0] SEG7_F = 7'h0E;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETTLE = 2'd1,
      HOLD   = 2'd2
   } seg7_dec_state_t;

   // True when exactly one active-low anode is asserted
   function automatic logic an_legal(input logic [NUM_DIGITS-1:0] an);
      logic [NUM_DIGITS-1:0] sel;
      sel = ~an;
      return (sel != '0) && ((sel & (sel - NUM_DIGITS'(1))) == '0);
   endfunction

   function automatic logic [2:0] an_index(input logic [NUM_DIGITS-1:0] an);
      logic [2:0] idx;
      idx = '0;
      for (int i = 0; i < NUM_DIGITS; i++)
         if (!an[i]) idx = 3'(i);
      return idx;
   endfunction

endpackage

// File: rtl/seg7_glyph_decode.sv
// Combinational seven-segment glyph to hex nibble decoder; `legal` flags
// patterns that are none of the sixteen hex glyphs.
module seg7_glyph_decode
   import seg7_pkg::*;
(
   input  logic [6:0] seg,
   output logic [3:0] nibble,
   output logic       legal
);

   always_comb begin
      nibble = 4'h0;
      legal  = 1'b1;
      case (seg)
         SEG7_0:  nibble = 4'h0;
         SEG7_1:  nibble = 4'h1;
         SEG7_2:  nibble = 4'h2;
         SEG7_3:  nibble = 4'h3;
         SEG7_4:  nibble = 4'h4;
         SEG7_5:  nibble = 4'h5;
         SEG7_6:  nibble = 4'h6;
         SEG7_7:  nibble = 4'h7;
         SEG7_8:  nibble = 4'h8;
         SEG7_9:  nibble = 4'h9;
         SEG7_A:  nibble = 4'hA;
         SEG7_B:  nibble = 4'hB;
         SEG7_C:  nibble = 4'hC;
         SEG7_D:  nibble = 4'hD;
         SEG7_E:  nibble = 4'hE;
         SEG7_F:  nibble = 4'hF;
         default: legal  = 1'b0;
      endcase
   end

endmodule

// File: rtl/seg7_scan_decoder.sv
// Monitors a multiplexed active-low 8-digit seven-segment bus and rebuilds the
// displayed hex value. Optional input synchronizer: SEG7_DEC_SYNC_EN.
module seg7_scan_decoder
   import seg7_pkg::*;
#(
   parameter int STABLE_CYCLES = 4,
   parameter int CNT_W         = 8
) (
   input  logic        clk_i,
   input  logic        arstn_i,
   input  logic [7:0]  an_i,
   input  logic [6:0]  seg_i,
   output logic [31:0] digits_o,
   output logic [7:0]  digit_valid_o,
   output logic        frame_o,
   output logic        err_o
);

   localparam logic [CNT_W-1:0] STABLE_C = CNT_W'(STABLE_CYCLES);
   localparam logic [CNT_W-1:0] ONE_C    = CNT_W'(1);

   logic [7:0] an_s;
   logic [6:0] seg_s;

`ifdef SEG7_DEC_SYNC_EN
   logic [7:0] an_m, an_q;
   logic [6:0] seg_m, seg_q;

   // Reset to all-ones so the synchronizer reads as a blank display
   always_ff @(posedge clk_i or negedge arstn_i) begin
      if (!arstn_i) begin
         an_m  <= '1;
         an_q  <= '1;
         seg_m <= '1;
         seg_q <= '1;
      end else begin
         an_m  <= an_i;
         an_q  <= an_m;
         seg_m <= seg_i;
         seg_q <= seg_m;
      end
   end

   assign an_s  = an_q;
   assign seg_s = seg_q;
`else
   assign an_s  = an_i;
   assign seg_s = seg_i;
`endif

   seg7_dec_state_t  state;
   logic [CNT_W-1:0] cnt;
   logic [7:0]       prev_an;
   logic [6:0]       prev_seg;
   logic [7:0]       seen;

   logic [3:0] dec_nib;
   logic       dec_legal;

   seg7_glyph_decode u_glyph (
      .seg    (seg_s),
      .nibble (dec_nib),
      .legal  (dec_legal)
   );

   logic             sel_ok;
   logic             same;
   logic             cap;
   logic [CNT_W-1:0] cnt_nxt;
   logic [2:0]       digit_idx;
   logic [7:0]       seen_nxt;

   // A changed pair always restarts at 1, so STABLE_CYCLES == 1 captures at once
   always_comb begin
      sel_ok    = an_legal(an_s);
      same      = (an_s == prev_an) && (seg_s == prev_seg);
      digit_idx = an_index(an_s);
      seen_nxt  = seen | (8'b1 << digit_idx);
      cnt_nxt   = '0;
      cap       = 1'b0;
      if (sel_ok) begin
         case (state)
            SETTLE:  cnt_nxt = same ? cnt + ONE_C : ONE_C;
            HOLD:    cnt_nxt = same ? cnt : ONE_C;
            default: cnt_nxt = ONE_C;
         endcase
         cap = (cnt_nxt == STABLE_C) && !((state == HOLD) && same);
      end
   end

   always_ff @(posedge clk_i or negedge arstn_i) begin
      if (!arstn_i) begin
         state         <= IDLE;
         cnt           <= '0;
         prev_an       <= '0;
         prev_seg      <= '0;
         seen          <= '0;
         digits_o      <= '0;
         digit_valid_o <= '0;
         frame_o       <= 1'b0;
         err_o         <= 1'b0;
      end else begin
         prev_an  <= an_s;
         prev_seg <= seg_s;
         cnt      <= cnt_nxt;
         frame_o  <= 1'b0;
         err_o    <= 1'b0;

         if (!sel_ok)
            state <= IDLE;
         else if (cap || ((state == HOLD) && same))
            state <= HOLD;
         else
            state <= SETTLE;

         if (cap) begin
            digits_o[4*digit_idx +: 4] <= dec_legal ? dec_nib : 4'h0;
            digit_valid_o[digit_idx]   <= dec_legal;
            err_o                      <= !dec_legal;
            // Repeat captures of an already-seen digit leave the mask unchanged
            if (&seen_nxt) begin
               frame_o <= 1'b1;
               seen    <= '0;
            end else begin
               seen <= seen_nxt;
            end
         end
      end
   end

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Scoreboard bench for seg7_scan_decoder: a run-length model of the bus pushes
// the expected outputs each cycle and a monitor pops and compares them.
module tb_seg7_scan_decoder;
   import seg7_pkg::*;

   localparam int STABLE = 4;
`ifdef SEG7_DEC_SYNC_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 0;
`endif

   logic        clk_i = 1'b0;
   logic        arstn_i;
   logic [7:0]  an_i;
   logic [6:0]  seg_i;
   logic [31:0] digits_o;
   logic [7:0]  digit_valid_o;
   logic        frame_o;
   logic        err_o;

   always #5 clk_i = ~clk_i;

   seg7_scan_decoder #(.STABLE_CYCLES(STABLE), .CNT_W(8)) dut (
      .clk_i         (clk_i),
      .arstn_i       (arstn_i),
      .an_i          (an_i),
      .seg_i         (seg_i),
      .digits_o      (digits_o),
      .digit_valid_o (digit_valid_o),
      .frame_o       (frame_o),
      .err_o         (err_o)
   );

   typedef struct packed {
      logic [31:0] digits;
      logic [7:0]  valid;
      logic        frame;
      logic        err;
   } exp_t;

   exp_t sb[$];
   exp_t e_mon;
   int   n_chk  = 0;
   int   n_fail = 0;

   logic [6:0] glyph [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                              7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

   // model state
   logic [14:0] m_last;
   logic [14:0] m_pipe [2];
   int          m_run;
   logic [31:0] m_dig;
   logic [7:0]  m_val;
   logic [7:0]  m_seen;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, want %h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_last    = '0;
      m_pipe[0] = '1;
      m_pipe[1] = '1;
      m_run     = 0;
      m_dig     = '0;
      m_val     = '0;
      m_seen    = '0;
   endtask

   task automatic model_step(input logic [14:0] raw);
      logic [14:0] p;
      logic [7:0]  an;
      logic [6:0]  sg;
      logic [3:0]  nib;
      logic        hit;
      int          k;
      exp_t        e;
      if (LAT == 2) begin
         p         = m_pipe[1];
         m_pipe[1] = m_pipe[0];
         m_pipe[0] = raw;
      end else begin
         p = raw;
      end
      an      = p[14:7];
      sg      = p[6:0];
      e.frame = 1'b0;
      e.err   = 1'b0;
      if ($countones(~an) == 1) begin
         m_run = (p == m_last) ? m_run + 1 : 1;
         if (m_run == STABLE) begin
            k = 0;
            for (int i = 0; i < 8; i++) if (!an[i]) k = i;
            hit = 1'b0;
            nib = 4'h0;
            for (int g = 0; g < 16; g++)
               if (glyph[g] == sg) begin hit = 1'b1; nib = 4'(g); end
            m_dig[4*k +: 4] = nib;
            m_val[k]        = hit;
            m_seen[k]       = 1'b1;
            e.err           = !hit;
            if (&m_seen) begin
               e.frame = 1'b1;
               m_seen  = '0;
            end
         end
      end else begin
         m_run = 0;
      end
      m_last   = p;
      e.digits = m_dig;
      e.valid  = m_val;
      sb.push_back(e);
   endtask

   // Called at a negedge; returns at a negedge after n sampled cycles
   task automatic drive(input logic [7:0] an, input logic [6:0] seg, input int n);
      for (int c = 0; c < n; c++) begin
         an_i  = an;
         seg_i = seg;
         @(posedge clk_i);
         model_step({an, seg});
         @(negedge clk_i);
      end
   endtask

   task automatic do_reset();
      arstn_i = 1'b0;
      #1;
      chk("rst_digits", digits_o, 32'h0);
      chk("rst_valid", {24'h0, digit_valid_o}, 32'h0);
      chk("rst_frame", {31'h0, frame_o}, 32'h0);
      chk("rst_err", {31'h0, err_o}, 32'h0);
      model_reset();
      @(negedge clk_i);
      @(negedge clk_i);
      arstn_i = 1'b1;
   endtask

   always @(posedge clk_i) begin
      #1;
      if (sb.size() > 0) begin
         e_mon = sb.pop_front();
         chk("digits", digits_o, e_mon.digits);
         chk("valid", {24'h0, digit_valid_o}, {24'h0, e_mon.valid});
         chk("frame", {31'h0, frame_o}, {31'h0, e_mon.frame});
         chk("err", {31'h0, err_o}, {31'h0, e_mon.err});
      end
   end

   initial begin
      logic [7:0] a;
      an_i  = '1;
      seg_i = '1;
      do_reset();

      // single digit capture on the 4th stable edge
      drive(8'hFE, 7'h24, 4);
      chk("d0_is_2", {28'h0, digits_o[3:0]}, 32'h2);

      // full scan of glyphs 1..8 -> 0x87654321, one frame
      for (int d = 0; d < 8; d++) begin
         a = ~(8'b1 << d);
         drive(a, glyph[d+1], 6);
      end
      chk("scan_value", digits_o, 32'h87654321);

      // toggling segments never settle, then a stable 3
      drive(8'hFB, 7'h24, 3);
      drive(8'hFB, 7'h30, 3);
      drive(8'hFB, 7'h24, 3);
      drive(8'hFB, 7'h30, 6);

      // change exactly on the would-be capture cycle
      drive(8'hEF, 7'h12, 3);
      drive(8'hEF, 7'h02, 5);

      // illegal selects: two low, then blank
      drive(8'hFC, 7'h24, 10);
      drive(8'hFF, 7'h7F, 10);

      // illegal glyph on digit 5, held beyond capture
      drive(8'hDF, 7'h7F, 5);
      chk("d5_valid", {31'h0, digit_valid_o[5]}, 32'h0);

      // reset mid-settle discards progress
      drive(8'hF7, 7'h19, 3);
      do_reset();
      drive(8'hF7, 7'h19, 6);

      // last digit illegal: frame and err on the same edge
      for (int d = 0; d < 7; d++) begin
         a = ~(8'b1 << d);
         drive(a, glyph[d+9], 5);
      end
      drive(8'h7F, 7'h7F, 5);

      @(negedge clk_i);
      chk("sb_drained", sb.size(), 32'h0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/seg7_scan_decoder.md
# seg7_scan_decoder

Receiving end of the seven-segment display interface. It watches a multiplexed, active-low anode/segment bus (8 digits, `gfedcba` segment order, bit 0 = segment a) and waits for each digit's pattern to settle. It then decodes the glyph back to a hex nibble and reassembles the full 8-digit value. The bench uses it as an on-chip display monitor to check the values driven onto HEX/anode lines.

## Interface
Parameters:
- `STABLE_CYCLES`, default 4: consecutive sampled cycles an anode/segment pair must hold unchanged before capture. Legal range is 1..255.
- `CNT_W`, default 8: settle counter width. It must satisfy 2^CNT_W > STABLE_CYCLES.

Ports:
- `clk_i`, input, 1: single system clock. All logic is on its rising edge.
- `arstn_i`, input, 1: reset, asynchronous and active-low.
- `an_i`, input, 8: digit anodes, active-low. A legal select is exactly one bit low.
- `seg_i`, input, 7: segments, active-low, `gfedcba`.
- `digits_o`, output, 32: digit k is held at bits `[4k+3:4k]`.
- `digit_valid_o`, output, 8: bit k = 1 when the last capture for digit k was a legal hex glyph.
- `frame_o`, output, 1: one-cycle pulse when all 8 digits have been captured since the previous pulse.
- `err_o`, output, 1: one-cycle pulse on capture of an illegal glyph.

## Operation
Sampling:
- `an_i`/`seg_i` form the sampled pair, taken directly or via the optional synchronizer (see Configuration).
- A register `prev` holds the previous sampled pair.

FSM states:
- IDLE: no legal anode select. Counter = 0.
- SETTLE: legal select, counting identical samples.
- HOLD: pair already captured; waiting for it to change.

Transitions:
- IDLE → SETTLE: the sample has exactly one anode bit low. Counter = 1.
- SETTLE, sample == `prev`: counter increments.
  - When the counter reaches `STABLE_CYCLES`, capture and go to HOLD.
  - `STABLE_CYCLES` = 1 captures on the entry cycle.
- SETTLE, sample != `prev` with a legal select: stay in SETTLE, counter = 1.
- Any state, illegal select (all high, or ≥2 low): go to IDLE, counter = 0.
- HOLD, sample == `prev`: stay in HOLD. No recapture.
- HOLD, sample != `prev`: go to SETTLE (legal select) or IDLE (illegal select).

Capture of digit k = index of the low anode bit:
- Decode the segment pattern as hex 0..F (active-low values):
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78
  - 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E
- Legal glyph: write the nibble to digit k and set `digit_valid_o[k]`.
- Any other pattern: write nibble 0, clear `digit_valid_o[k]`, pulse `err_o`.
- In both cases, set bit k of the internal `seen` mask.

Frame completion:
- On the capture that makes `seen` all ones, pulse `frame_o` and clear `seen` in the same edge.
- Capturing a digit already present in `seen` overwrites its nibble and does not affect frame detection.

## Timing
Reset (`arstn_i` low, asynchronous):
- State IDLE, counter 0, `prev` 0, `seen` 0.
- `digits_o` = 0, `digit_valid_o` = 0, `frame_o` = 0, `err_o` = 0.
- Reset mid-SETTLE or mid-frame discards all partial progress.

Latency:
- Capture happens at the rising edge on which the pair has been sampled identically for `STABLE_CYCLES` consecutive edges.
- `digits_o`, `digit_valid_o`, `err_o` and `frame_o` are registered and change on that same edge.
- With the synchronizer, add 2 cycles from the pin.

Pulse rules:
- `frame_o` and `err_o` are high for exactly one cycle.
- Both may pulse on the same edge (last digit illegal).

Settling rule:
- A pair change on the cycle the counter would reach `STABLE_CYCLES` restarts the count. No capture occurs.

## Configuration
`SEG7_DEC_SYNC_EN`:
- Defined: a 2-flop synchronizer (reset to all-ones, i.e. blank) is inserted on `an_i` and `seg_i`. Latency +2 cycles.
- Undefined: inputs are sampled directly, for same-clock-domain sources.
- Functional behaviour is otherwise identical.

## Structure
- Package `seg7_pkg`:
  - `localparam` glyph constants `SEG7_0`..`SEG7_F` (7-bit, active-low).
  - FSM state enum `seg7_dec_state_t` (IDLE, SETTLE, HOLD).
  - `NUM_DIGITS` = 8.
- Sub-module `seg7_glyph_decode`:
  - Combinational, 7-bit pattern in → 4-bit nibble + `legal` flag out.
  - Reusable by any future display consumer.

## Test plan
- Drive `an_i`=FE, `seg_i`=24 for 4 cycles → on the 4th edge `digits_o[3:0]`=2 and `digit_valid_o[0]`=1; no `frame_o`.
- Scan digits 0..7 with glyphs 1..8 (values 79,24,30,19,12,02,78,00), 6 cycles each → `digits_o`=0x87654321, `digit_valid_o`=FF, a single `frame_o` pulse on digit 7's capture edge, `seen` cleared.
- `an_i`=FB with `seg_i` toggling 24/30 every 3 cycles, then held at 30 → no capture until 4 stable cycles, then `digits_o[11:8]`=3.
- `an_i`=FC (two low), then FF (blank), each for 10 cycles → stays IDLE; outputs unchanged; no pulses.
- Digit 5 with `seg_i`=7F held 5 cycles → `err_o` pulses once, `digits_o[23:20]`=0, `digit_valid_o[5]`=0; no repeated pulse while held.
- Assert `arstn_i` low at counter=3 during SETTLE, release → all outputs 0; after release, a fresh 4-cycle hold is needed for capture.
